// File: rtl/tone_pkg.sv
// Shared widths and a small elaboration helper for the tone generator.
package tone_pkg;
  localparam int PERIOD_W = 8;
  localparam int MIX_W    = 2;

  function automatic int pc_width(input int prescale);
    if (prescale > 1) begin
      return $clog2(prescale);
    end else begin
      return 1;
    end
  endfunction
endpackage

// File: rtl/tone_channel.sv
// One square-wave channel: each level lasts the captured half-period, measured in ticks.
module tone_channel
  import tone_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [PERIOD_W-1:0] per,
  output logic                sq
);

  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] active_q, active_d;
  logic                sq_q, sq_d;

  // Period changes are only honoured at a level boundary (cnt == 0), so no runt pulses.
  always_comb begin
    per_d    = per;
    cnt_d    = cnt_q;
    active_d = active_q;
    sq_d     = sq_q;
    if (tick) begin
      if (cnt_q != {PERIOD_W{1'b0}}) begin
        cnt_d = cnt_q - {{(PERIOD_W-1){1'b0}}, 1'b1};
      end else begin
        active_d = per_q;
        if (per_q == {PERIOD_W{1'b0}}) begin
          sq_d  = 1'b0;
          cnt_d = {PERIOD_W{1'b0}};
        end else if (active_q == {PERIOD_W{1'b0}}) begin
          sq_d  = 1'b1;
          cnt_d = per_q - {{(PERIOD_W-1){1'b0}}, 1'b1};
        end else begin
          sq_d  = ~sq_q;
          cnt_d = per_q - {{(PERIOD_W-1){1'b0}}, 1'b1};
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q    <= {PERIOD_W{1'b0}};
      cnt_q    <= {PERIOD_W{1'b0}};
      active_q <= {PERIOD_W{1'b0}};
      sq_q     <= 1'b0;
    end else begin
      per_q    <= per_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      sq_q     <= sq_d;
    end
  end

  assign sq = sq_q;

endmodule

// File: rtl/tone_gen.sv
// Two-channel square-wave tone generator with a shared prescaler, 2-bit mix and
// first-order sigma-delta PDM output.
module tone_gen
  import tone_pkg::*;
#(
  parameter int PRESCALE = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PERIOD_W-1:0] freq1,
  input  logic [PERIOD_W-1:0] freq2,
  output logic                sq1,
  output logic                sq2,
  output logic [MIX_W-1:0]    mix,
  output logic                pdm_out
);

  localparam int              PC_W   = pc_width(PRESCALE);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(PRESCALE - 1);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             tick_s;
  logic             sq1_s, sq2_s;
  logic [MIX_W-1:0] mix_q, mix_d;
  logic [MIX_W-1:0] sum_s;
  logic             acc_q, acc_d;
  logic             pdm_q, pdm_d;

  tone_channel u_ch1 (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s),
    .per   (freq1),
    .sq    (sq1_s)
  );

  tone_channel u_ch2 (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s),
    .per   (freq2),
    .sq    (sq2_s)
  );

  // Prescaler, mix and PDM next-state; s >= 2 is just the top bit, and s - 2 leaves the low bit.
  always_comb begin
    tick_s = (pc_q == PC_MAX);
    if (tick_s) begin
      pc_d = {PC_W{1'b0}};
    end else begin
      pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    end
    mix_d = {1'b0, sq1_s} + {1'b0, sq2_s};
    sum_s = {1'b0, acc_q} + mix_q;
    pdm_d = sum_s[1];
    acc_d = sum_s[0];
  end

  // Prescaler, mix and PDM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= {PC_W{1'b0}};
      mix_q <= {MIX_W{1'b0}};
      acc_q <= 1'b0;
      pdm_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mix_q <= mix_d;
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end

  assign sq1     = sq1_s;
  assign sq2     = sq2_s;
  assign mix     = mix_q;
  assign pdm_out = pdm_q;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_tone_gen;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n  = 1'b0;
  logic [7:0] a1 = 8'd0, a2 = 8'd0, b1 = 8'd0, b2 = 8'd0;
  logic       p1_sq1, p1_sq2, p1_pdm, p4_sq1, p4_sq2, p4_pdm;
  logic [1:0] p1_mix, p4_mix;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 if (clk_en) clk = ~clk;

  tone_gen #(.PRESCALE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .freq1(a1), .freq2(a2),
    .sq1(p1_sq1), .sq2(p1_sq2), .mix(p1_mix), .pdm_out(p1_pdm)
  );

  tone_gen #(.PRESCALE(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .freq1(b1), .freq2(b2),
    .sq1(p4_sq1), .sq2(p4_sq2), .mix(p4_mix), .pdm_out(p4_pdm)
  );

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Release lands 1 ns after an edge, so the next edge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) edge1();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    a1 = 8'd1; a2 = 8'd1; b1 = 8'd3; b2 = 8'd0;
    do_reset();
    repeat (21) edge1();
    @(negedge clk);
    clk_en = 1'b0;
    #20;
    rst_n = 1'b0;
    #1;
    obs = {p1_sq1, p1_sq2, p1_mix, p1_pdm, p4_sq1, p4_sq2, p4_mix, p4_pdm};
    n_checks++;
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_async: outputs=%b expected=%b", obs, 10'd0);
    end
    a1 = 8'd0; a2 = 8'd0; b1 = 8'd0; b2 = 8'd0;
    clk_en = 1'b1;
    repeat (2) edge1();
    rst_n = 1'b1;
    for (int n = 1; n <= 2000; n++) begin
      edge1();
      obs = {p1_sq1, p1_sq2, p1_mix, p1_pdm, p4_sq1, p4_sq2, p4_mix, p4_pdm};
      n_checks++;
      if (obs !== 10'd0) begin
        n_fail++;
        $display("FAIL mute_idle: cycle %0d outputs=%b expected=%b", n, obs, 10'd0);
      end
    end
  endtask

  task automatic test_fastest();
    logic       e_sq, e_pdm;
    logic [1:0] e_mix;
    a1 = 8'd1; a2 = 8'd0;
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      edge1();
      e_sq  = (n >= 2) && (n % 2 == 0);
      e_mix = ((n >= 3) && (n % 2 == 1)) ? 2'd1 : 2'd0;
      e_pdm = (n >= 6) && (n % 4 == 2);
      n_checks++;
      if ({p1_sq1, p1_sq2, p1_mix, p1_pdm} !== {e_sq, 1'b0, e_mix, e_pdm}) begin
        n_fail++;
        $display("FAIL fastest: cycle %0d sq1=%b sq2=%b mix=%0d pdm=%b expected sq1=%b sq2=0 mix=%0d pdm=%b",
                 n, p1_sq1, p1_sq2, p1_mix, p1_pdm, e_sq, e_mix, e_pdm);
      end
    end
  endtask

  task automatic test_equal();
    logic       e_sq, e_pdm;
    logic [1:0] e_mix;
    b1 = 8'd20; b2 = 8'd20;
    do_reset();
    for (int n = 1; n <= 400; n++) begin
      edge1();
      e_sq  = (n >= 4) && (((n - 4) / 80) % 2 == 0);
      e_mix = ((n >= 5) && (((n - 5) / 80) % 2 == 0)) ? 2'd2 : 2'd0;
      e_pdm = (n >= 6) && (((n - 6) / 80) % 2 == 0);
      n_checks++;
      if ({p4_sq1, p4_sq2, p4_mix, p4_pdm} !== {e_sq, e_sq, e_mix, e_pdm}) begin
        n_fail++;
        $display("FAIL equal_channels: cycle %0d sq1=%b sq2=%b mix=%0d pdm=%b expected sq=%b mix=%0d pdm=%b",
                 n, p4_sq1, p4_sq2, p4_mix, p4_pdm, e_sq, e_mix, e_pdm);
      end
    end
  endtask

  task automatic test_period_change();
    logic e_sq;
    b1 = 8'd20; b2 = 8'd0;
    do_reset();
    for (int n = 1; n <= 300; n++) begin
      edge1();
      if (n < 4)       e_sq = 1'b0;
      else if (n < 84) e_sq = 1'b1;
      else             e_sq = (((n - 84) / 20) % 2 == 1);
      n_checks++;
      if (p4_sq1 !== e_sq) begin
        n_fail++;
        $display("FAIL period_change: cycle %0d sq1=%b expected=%b", n, p4_sq1, e_sq);
      end
      if (n == 34) b1 = 8'd5;
    end
  endtask

  task automatic test_stop();
    logic e_sq;
    int   rise_at;
    b1 = 8'd24; b2 = 8'd0;
    do_reset();
    for (int n = 1; n <= 200; n++) begin
      edge1();
      e_sq = (n >= 4) && (n < 100);
      n_checks++;
      if (p4_sq1 !== e_sq) begin
        n_fail++;
        $display("FAIL channel_stop: cycle %0d sq1=%b expected=%b", n, p4_sq1, e_sq);
      end
      if (n == 50) b1 = 8'd0;
    end
    b1 = 8'd1;
    rise_at = 0;
    for (int k = 1; k <= 5; k++) begin
      edge1();
      if (p4_sq1 === 1'b1) begin
        rise_at = k;
        break;
      end
    end
    n_checks++;
    if (rise_at != 4) begin
      n_fail++;
      $display("FAIL unmute_latency: rise after %0d clk (0 = none within 5) expected 4", rise_at);
    end
  endtask

  task automatic test_reset_mid();
    logic e_sq;
    b1 = 8'd3; b2 = 8'd0;
    do_reset();
    repeat (35) edge1();
    n_checks++;
    if (p4_sq1 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_level: sq1=%b expected=1", p4_sq1);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({p4_sq1, p4_sq2, p4_mix, p4_pdm} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid: outputs=%b expected=%b", {p4_sq1, p4_sq2, p4_mix, p4_pdm}, 5'd0);
    end
    #1;
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      edge1();
      e_sq = (n >= 4) && (n < 16);
      n_checks++;
      if (p4_sq1 !== e_sq) begin
        n_fail++;
        $display("FAIL restart: cycle %0d sq1=%b expected=%b", n, p4_sq1, e_sq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fastest();
    test_equal();
    test_period_change();
    test_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
